rtc_bus_sequencer: RTL and testbench
====================================

Name: rtc_bus_sequencer

Overview:
- Parametrised multi-channel bus master for the multiplexed address/data RTC interface (AD, CS, RD, WR, 8-bit AD bus).
- Replaces the fixed select mux, where each sub-FSM drives raw strobes, with a single timing engine.
- Requesters (init, time/date read, time/date write, chrono start) post burst read/write requests. A round-robin arbiter grants one channel at a time, and the sequencer generates all bus phases with programmable phase lengths.
- Sits between the control FSMs and the top-level RTC pins.

Parameters:
- NCH, 4, number of requester channels (2..8).
- AW, 8, register address width.
- DW, 8, data width (equals AW on the multiplexed bus).
- LW, 3, burst length field width; a burst is len+1 beats (max 8).
- T_PH, 4, clocks per active phase (address or data strobe), >=1.
- T_GAP, 2, clocks of idle gap after each phase, >=1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active low.
- req  in  NCH  per-channel request level.
- req_wr  in  NCH  per-channel direction: 1 = write, 0 = read.
- req_addr  in  NCH*AW  per-channel start address; channel i uses bits [i*AW +: AW].
- req_len  in  NCH*LW  per-channel beat count minus 1.
- req_wdata  in  NCH*DW  per-channel write data lane.
- gnt  out  NCH  one-hot grant, held for the whole transaction.
- wdata_take  out  1  one-cycle pulse: the granted channel's wdata lane is captured this cycle.
- rdata  out  DW  read data.
- rdata_vld  out  1  one-cycle pulse: rdata valid.
- done  out  1  one-cycle pulse on the last cycle of a transaction.
- busy  out  1  high while not IDLE.
- ad_in  in  DW  bus data from the pad.
- ad_out  out  DW  bus data to the pad.
- ad_oe  out  1  pad output enable.
- ad  out  1  address/data select: 0 = address phase.
- cs  out  1  chip select, active low.
- rd  out  1  read strobe, active low.
- wr  out  1  write strobe, active low.

Behaviour:
- Reset (async, rst=0):
  - State IDLE.
  - cs=rd=wr=ad=1.
  - ad_oe=0, ad_out=0.
  - gnt=0, rdata=0, all pulses 0.
  - Round-robin pointer = 0.
  - Reset mid-transaction aborts immediately. There is no completion and no done pulse.
- All outputs are registered.
- States: IDLE, ADDR, GAP_A, DATA, GAP_D.
- IDLE:
  - If any req is high, select the first requester scanning from the pointer upward, mod NCH.
  - Latch that channel's wr, addr and len; set the beat counter to 0.
  - Assert gnt[i] and enter ADDR on the next edge, so request-to-ADDR latency is 1 clock.
- ADDR (T_PH cycles): cs=0, ad=0, wr=0, rd=1, ad_oe=1, ad_out = current address. Address strobe is used for both read and write transactions.
- GAP_A (T_GAP cycles): cs=rd=wr=ad=1, ad_oe=1, ad_out held.
- DATA (T_PH cycles): cs=0, ad=1.
  - Write: wr=0, ad_oe=1, ad_out = wdata captured on the first DATA cycle; wdata_take pulses on that same cycle.
  - Read: rd=0, ad_oe=0; ad_in is sampled on the last DATA cycle.
- GAP_D (T_GAP cycles): all strobes high, ad_oe=0.
  - On read beats, rdata/rdata_vld are presented on the first GAP_D cycle.
  - At the end of GAP_D: if beat == len, pulse done and clear gnt and busy in that same cycle, set pointer = granted+1 mod NCH, and go to IDLE.
  - Otherwise increment beat, set address = address+1 (wraps mod 2^AW), and go to ADDR.
- Beat timing: one beat = 2*(T_PH+T_GAP) clocks. A transaction lasts 1 + (len+1)*2*(T_PH+T_GAP) clocks including the grant cycle.
- req, req_wr, req_addr and req_len are sampled only in IDLE. Changes or deassertion during a transaction are ignored; the burst always completes.
- The requester must drop req by the cycle after done, or it re-enters arbitration behind the other channels.
- No two strobes of rd/wr are ever low together. cs is never low while ad_oe would contend (read DATA has ad_oe=0).
- Idle gap between back-to-back transactions: at least 1 IDLE cycle with all strobes high.

Test Plan:
- Single write, ch0: addr=0x21, len=0, wdata=0x45, T_PH=4, T_GAP=2 -> ad low 4 clks with ad_out=0x21; wr low both phases; 4-clk data phase with ad_out=0x45; wdata_take 1 pulse; done 13 clks after req sampled; gnt=0001 throughout.
- Read burst, ch2: addr=0x22, len=2, pad returns 0x11/0x09/0x16 -> addresses 0x22, 0x23, 0x24 issued; rdata_vld 3 pulses with 0x11, 0x09, 0x16; rd never low with wr.
- Address wrap: addr=0xFF, len=1 read -> second address phase drives 0x00.
- Round robin: req=1111 held continuously -> grants in order 0,1,2,3,0; each done is followed by a different gnt bit.
- Simultaneous/late requests: ch1 and ch3 raise req in the same cycle with pointer=2 -> ch3 granted first, then ch1. ch1 dropping req mid-burst of ch3 has no effect on ch3.
- Reset mid-burst: rst low during a DATA phase -> cs/rd/wr/ad=1, ad_oe=0 and gnt=0 asynchronously; no done. After release with req held, the transaction restarts from ch0 with a fresh address phase.

Source files
------------

// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer: round-robin multi-channel burst master for the multiplexed AD/CS/RD/WR RTC bus
module rtc_bus_sequencer #(
  parameter int NCH   = 4,
  parameter int AW    = 8,
  parameter int DW    = 8,
  parameter int LW    = 3,
  parameter int T_PH  = 4,
  parameter int T_GAP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    req,
  input  logic [NCH-1:0]    req_wr,
  input  logic [NCH*AW-1:0] req_addr,
  input  logic [NCH*LW-1:0] req_len,
  input  logic [NCH*DW-1:0] req_wdata,
  output logic [NCH-1:0]    gnt,
  output logic              wdata_take,
  output logic [DW-1:0]     rdata,
  output logic              rdata_vld,
  output logic              done,
  output logic              busy,
  input  logic [DW-1:0]     ad_in,
  output logic [DW-1:0]     ad_out,
  output logic              ad_oe,
  output logic              ad,
  output logic              cs,
  output logic              rd,
  output logic              wr
);
  localparam int PW = NCH > 1 ? $clog2(NCH) : 1;
  localparam int TM = T_PH > T_GAP ? T_PH : T_GAP;
  localparam int CW = $clog2(TM) + 1;
  typedef enum logic [2:0] {IDLE, ADDR, GAP_A, DATA, GAP_D} state_t;
  state_t st, ns;
  logic [CW-1:0] cnt, cnt_n;
  logic [LW-1:0] beat, beat_n, len, len_n;
  logic [AW-1:0] addr, addr_n;
  logic dir, dir_n;
  logic [PW-1:0] ch, ch_n, ptr, ptr_n, sel, idx;
  logic [NCH-1:0] gnt_n;
  logic [DW-1:0] rdata_n, ad_out_n;
  logic take_n, vld_n, done_n, busy_n, oe_n, ad_n, cs_n, rd_n, wr_n;
  // Descending scan so the lowest offset from the pointer wins.
  always_comb begin
    sel = ptr;
    idx = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % NCH);
      if (req[idx]) sel = idx;
    end
  end
  always_comb begin
    ns = st;
    cnt_n = cnt + 1'b1;
    beat_n = beat;
    len_n = len;
    addr_n = addr;
    dir_n = dir;
    ch_n = ch;
    ptr_n = ptr;
    gnt_n = gnt;
    done_n = 1'b0;
    take_n = 1'b0;
    vld_n = 1'b0;
    rdata_n = rdata;
    ad_out_n = ad_out;
    case (st)
      IDLE: begin
        cnt_n = '0;
        if (|gnt) ns = ADDR;
        else if (|req && !done) begin
          gnt_n = NCH'(1) << sel;
          ch_n = sel;
          dir_n = req_wr[sel];
          addr_n = req_addr[sel*AW +: AW];
          len_n = req_len[sel*LW +: LW];
          beat_n = '0;
        end
      end
      ADDR: if (cnt == CW'(T_PH - 1)) begin
        ns = GAP_A;
        cnt_n = '0;
      end
      GAP_A: if (cnt == CW'(T_GAP - 1)) begin
        ns = DATA;
        cnt_n = '0;
        take_n = dir;
        ad_out_n = dir ? req_wdata[ch*DW +: DW] : ad_out;
      end
      DATA: if (cnt == CW'(T_PH - 1)) begin
        ns = GAP_D;
        cnt_n = '0;
        vld_n = !dir;
        rdata_n = dir ? rdata : ad_in;
      end
      GAP_D: if (cnt == CW'(T_GAP - 1)) begin
        cnt_n = '0;
        if (beat == len) begin
          ns = IDLE;
          done_n = 1'b1;
          gnt_n = '0;
          ptr_n = (ch == PW'(NCH - 1)) ? '0 : ch + 1'b1;
        end else begin
          ns = ADDR;
          beat_n = beat + 1'b1;
          addr_n = addr + 1'b1;
        end
      end
      default: ns = IDLE;
    endcase
    ad_out_n = (ns == ADDR) ? DW'(addr_n) : ad_out_n;
    cs_n = !(ns == ADDR || ns == DATA);
    ad_n = ns != ADDR;
    wr_n = !(ns == ADDR || (ns == DATA && dir));
    rd_n = !(ns == DATA && !dir);
    oe_n = ns == ADDR || ns == GAP_A || (ns == DATA && dir);
    busy_n = |gnt_n;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= IDLE;
      cnt <= '0;
      beat <= '0;
      len <= '0;
      addr <= '0;
      dir <= 1'b0;
      ch <= '0;
      ptr <= '0;
      gnt <= '0;
      wdata_take <= 1'b0;
      rdata <= '0;
      rdata_vld <= 1'b0;
      done <= 1'b0;
      busy <= 1'b0;
      ad_out <= '0;
      ad_oe <= 1'b0;
      ad <= 1'b1;
      cs <= 1'b1;
      rd <= 1'b1;
      wr <= 1'b1;
    end else begin
      st <= ns;
      cnt <= cnt_n;
      beat <= beat_n;
      len <= len_n;
      addr <= addr_n;
      dir <= dir_n;
      ch <= ch_n;
      ptr <= ptr_n;
      gnt <= gnt_n;
      wdata_take <= take_n;
      rdata <= rdata_n;
      rdata_vld <= vld_n;
      done <= done_n;
      busy <= busy_n;
      ad_out <= ad_out_n;
      ad_oe <= oe_n;
      ad <= ad_n;
      cs <= cs_n;
      rd <= rd_n;
      wr <= wr_n;
    end
  end
endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// tb_rtc_bus_sequencer: randomized bench with an RTC pad model and a transaction-level timing model
module tb_rtc_bus_sequencer;
  localparam int NCH = 4, AW = 8, DW = 8, LW = 3, P = 4, G = 2, B = 2 * (P + G);
  logic clk = 1'b0, rst = 1'b0;
  logic [NCH-1:0] req = '0, req_wr = '0;
  logic [NCH*AW-1:0] req_addr = '0;
  logic [NCH*LW-1:0] req_len = '0;
  logic [NCH*DW-1:0] req_wdata = '0;
  logic [NCH-1:0] gnt;
  logic wdata_take, rdata_vld, done, busy, ad_oe, ad, cs, rd, wr;
  logic [DW-1:0] rdata, ad_in, ad_out;
  logic [7:0] pad_mem [256];
  logic [7:0] exp_mem [256];
  logic [7:0] pad_lat = '0;
  logic pad_load = 1'b0;
  int compared = 0, mismatched = 0, ptr_m = 0, mid_ch = -1;
  logic c_wr [NCH];
  logic [7:0] c_addr [NCH];
  int c_len [NCH];
  logic [7:0] c_wd [NCH][8];

  rtc_bus_sequencer #(.NCH(NCH), .AW(AW), .DW(DW), .LW(LW), .T_PH(P), .T_GAP(G)) dut (
    .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr), .req_len(req_len),
    .req_wdata(req_wdata), .gnt(gnt), .wdata_take(wdata_take), .rdata(rdata), .rdata_vld(rdata_vld),
    .done(done), .busy(busy), .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe), .ad(ad), .cs(cs),
    .rd(rd), .wr(wr));

  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // RTC register file on the pad side: latches the address phase, stores write data.
  assign ad_in = pad_mem[pad_lat];
  always @(negedge clk) begin
    if (pad_load) for (int i = 0; i < 256; i++) pad_mem[i] <= exp_mem[i];
    else begin
      if (!cs && !ad) pad_lat <= ad_out;
      if (!cs && ad && !wr) pad_mem[pad_lat] <= ad_out;
    end
  end

  function automatic int arb_pick();
    for (int k = 0; k < NCH; k++) if (req[(ptr_m + k) % NCH]) return (ptr_m + k) % NCH;
    return -1;
  endfunction

  task automatic cfg(input int c, input bit w, input logic [7:0] a, input int l);
    c_wr[c] = w;
    c_addr[c] = a;
    c_len[c] = l;
    for (int b = 0; b < 8; b++) c_wd[c][b] = 8'($urandom);
    req_wr[c] = w;
    req_addr[c*8 +: 8] = a;
    req_len[c*3 +: 3] = 3'(l);
    req_wdata[c*8 +: 8] = c_wd[c][0];
  endtask

  task automatic wait_grant(input int exp_ch, input int exp_lat, output bit ok);
    int n = 0;
    while (gnt == '0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    compared++;
    ok = gnt === (4'b0001 << exp_ch);
    if (!ok) begin
      mismatched++;
      $display("FAIL grant got=%b exp=%b", gnt, 4'b0001 << exp_ch);
    end
    if (exp_lat > 0) begin
      compared++;
      if (n != exp_lat) begin
        mismatched++;
        $display("FAIL grant_latency got=%0d exp=%0d", n, exp_lat);
      end
    end
  endtask

  // Walks a granted transaction from its grant cycle to its done cycle.
  task automatic check_txn(input int c);
    int n = (c_len[c] + 1) * B;
    for (int k = 0; k <= n + 1; k++) begin
      int t, b, p;
      logic [8:0] e, o;
      logic [3:0] eg;
      logic [7:0] ea, ed, ab;
      bit ca, cv;
      if (k > 0) @(negedge clk);
      t = k - 1;
      b = (k > 0) ? t / B : 0;
      p = (k > 0) ? t % B : 0;
      ab = c_addr[c] + 8'(b);
      ca = 1'b0;
      cv = 1'b0;
      ea = '0;
      ed = '0;
      eg = 4'b0001 << c;
      if (k == 0) e = 9'b1111_0000_1;
      else if (k == n + 1) begin
        e = 9'b1111_0001_0;
        eg = '0;
      end else if (p < P) begin
        e = 9'b0010_1000_1;
        ca = 1'b1;
        ea = ab;
      end else if (p < P + G) begin
        e = 9'b1111_1000_1;
        ca = 1'b1;
        ea = ab;
      end else if (p < 2 * P + G) begin
        if (c_wr[c]) begin
          e = {5'b01101, 1'(p == P + G), 3'b001};
          ca = 1'b1;
          ea = c_wd[c][b];
        end else e = 9'b0101_0000_1;
      end else begin
        cv = !c_wr[c] && p == 2 * P + G;
        e = {6'b111100, cv, 2'b01};
        ed = exp_mem[ab];
      end
      o = {cs, ad, rd, wr, ad_oe, wdata_take, rdata_vld, done, busy};
      compared++;
      if (o !== e || gnt !== eg) begin
        mismatched++;
        $display("FAIL bus ch=%0d k=%0d got=%b/%b exp=%b/%b", c, k, o, gnt, e, eg);
      end
      compared++;
      if ((!rd && !wr) || (!rd && ad_oe)) begin
        mismatched++;
        $display("FAIL strobe_clash ch=%0d k=%0d rd=%b wr=%b oe=%b", c, k, rd, wr, ad_oe);
      end
      if (ca) begin
        compared++;
        if (ad_out !== ea) begin
          mismatched++;
          $display("FAIL ad_out ch=%0d k=%0d got=%h exp=%h", c, k, ad_out, ea);
        end
      end
      if (cv) begin
        compared++;
        if (rdata !== ed) begin
          mismatched++;
          $display("FAIL rdata ch=%0d beat=%0d got=%h exp=%h", c, b, rdata, ed);
        end
      end
      if (k == 5 && mid_ch >= 0) begin
        req[mid_ch] = 1'b0;
        req_addr[mid_ch*8 +: 8] = ~c_addr[mid_ch];
        req_wr[mid_ch] = ~c_wr[mid_ch];
        req_len[mid_ch*3 +: 3] = ~3'(c_len[mid_ch]);
      end
      if (k > 0 && k <= n && p == P + G && c_wr[c] && b < c_len[c]) req_wdata[c*8 +: 8] = c_wd[c][b+1];
    end
    if (c_wr[c]) for (int b = 0; b <= c_len[c]; b++) exp_mem[8'(c_addr[c] + 8'(b))] = c_wd[c][b];
    req_wdata[c*8 +: 8] = c_wd[c][0];
    ptr_m = (c + 1) % NCH;
  endtask

  task automatic check_idle(input string tag);
    compared++;
    if ({cs, ad, rd, wr, ad_oe, wdata_take, rdata_vld, done, busy} !== 9'b1111_0000_0 || gnt !== '0 || ad_out !== '0 || rdata !== '0) begin
      mismatched++;
      $display("FAIL %s got cs%b ad%b rd%b wr%b oe%b gnt=%b ad_out=%h rdata=%h busy%b done%b exp idle/zero",
               tag, cs, ad, rd, wr, ad_oe, gnt, ad_out, rdata, busy, done);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'($urandom);
    exp_mem[8'h22] = 8'h11;
    exp_mem[8'h23] = 8'h09;
    exp_mem[8'h24] = 8'h16;
    pad_load = 1'b1;
    repeat (3) @(negedge clk);
    pad_load = 1'b0;
    check_idle("reset_held");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("reset_released");
  endtask

  task automatic run_one(input int c, input bit w, input logic [7:0] a, input int l, input int lat);
    bit ok;
    @(negedge clk);
    cfg(c, w, a, l);
    req[c] = 1'b1;
    wait_grant(arb_pick(), lat, ok);
    if (ok) check_txn(c);
    req[c] = 1'b0;
  endtask

  task automatic test_single_write();
    bit ok;
    @(negedge clk);
    cfg(0, 1'b1, 8'h21, 0);
    c_wd[0][0] = 8'h45;
    req_wdata[7:0] = 8'h45;
    req[0] = 1'b1;
    wait_grant(0, 1, ok);
    if (ok) check_txn(0);
    req[0] = 1'b0;
  endtask

  task automatic test_read_burst();
    run_one(2, 1'b0, 8'h22, 2, 1);
  endtask

  task automatic test_wrap();
    run_one(3, 1'b0, 8'hFF, 1, 1);
  endtask

  task automatic test_round_robin();
    bit ok;
    @(negedge clk);
    for (int c = 0; c < NCH; c++) cfg(c, 1'($urandom), 8'($urandom), $urandom_range(0, 2));
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_grant((ptr_m) % NCH, i == 0 ? 1 : 2, ok);
      if (ok) check_txn((i) % NCH);
    end
    req = '0;
  endtask

  task automatic test_simultaneous();
    bit ok;
    run_one(1, 1'b1, 8'h40, 0, 1);
    @(negedge clk);
    cfg(1, 1'b0, 8'h10, 1);
    cfg(3, 1'b1, 8'h50, 2);
    req[1] = 1'b1;
    req[3] = 1'b1;
    mid_ch = 3;
    wait_grant(3, 1, ok);
    if (ok) check_txn(3);
    mid_ch = -1;
    wait_grant(1, 2, ok);
    if (ok) check_txn(1);
    req = '0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    @(negedge clk);
    cfg(2, 1'b0, 8'h33, 1);
    req[2] = 1'b1;
    wait_grant(arb_pick(), 1, ok);
    repeat (P + G + 2) @(negedge clk);
    compared++;
    if (rd !== 1'b0 || cs !== 1'b0) begin
      mismatched++;
      $display("FAIL pre_reset_data got rd=%b cs=%b exp rd=0 cs=0", rd, cs);
    end
    cfg(0, 1'($urandom), 8'($urandom), 1);
    req[0] = 1'b1;
    #2 rst = 1'b0;
    #1;
    compared++;
    if ({cs, ad, rd, wr, ad_oe, busy, done} !== 7'b1111_000 || gnt !== '0) begin
      mismatched++;
      $display("FAIL async_reset got cs%b ad%b rd%b wr%b oe%b busy%b gnt=%b exp all strobes high, oe/gnt 0",
               cs, ad, rd, wr, ad_oe, busy, gnt);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compared++;
      if (done !== 1'b0 || gnt !== '0) begin
        mismatched++;
        $display("FAIL reset_no_done got done=%b gnt=%b exp 0/0", done, gnt);
      end
    end
    rst = 1'b1;
    ptr_m = 0;
    wait_grant(0, 1, ok);
    if (ok) check_txn(0);
    req[0] = 1'b0;
    wait_grant(2, 2, ok);
    if (ok) check_txn(2);
    req[2] = 1'b0;
  endtask

  task automatic test_random();
    bit ok;
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      req = 4'($urandom_range(1, 15));
      for (int c = 0; c < NCH; c++) if (req[c]) cfg(c, 1'($urandom), 8'($urandom), $urandom_range(0, 7));
      while (req != '0) begin
        int e = arb_pick();
        wait_grant(e, 0, ok);
        if (ok) check_txn(e);
        req[e] = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_burst();
    test_wrap();
    test_round_robin();
    test_simultaneous();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
